pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the successor to the fixed-field EX/MEM register. It carries one instruction's payload (data words, control bits, destination register) between two pipeline stages, and adds three things the plain register lacks:
- a valid/ready handshake backed by a 2-entry skid buffer, so a stalled downstream stage (e.g. a multi-cycle data memory) applies back-pressure without a combinational ready path;
- a synchronous flush that turns in-flight entries into bubbles;
- saturating stall and bubble performance counters.

---
 rtl/pipe_stage_reg.sv | 197 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Inter-stage pipeline register carrying one instruction payload
//   {data, ctrl, rd} between two pipeline stages.
//   - valid/ready handshake backed by a 2-entry skid buffer (main + skid).
//     in_ready is decoded from the registered state only, so there is no
//     combinational path from out_ready or in_valid to in_ready.
//   - synchronous flush squashes all held entries into bubbles.
//   - saturating stall / bubble performance counters with synchronous clear.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   in_valid   in   upstream has an instruction
//   in_ready   out  stage can accept (EMPTY or ONE)
//   in_data    in   [DATA_W] upstream payload
//   in_ctrl    in   [CTRL_W] upstream control bits (all-zero = no-op)
//   in_rd      in   [RD_W]   upstream destination register
//   flush      in   synchronous squash of all held entries
//   out_valid  out  head entry present
//   out_ready  in   downstream consumes the head this cycle
//   out_data   out  [DATA_W] head payload
//   out_ctrl   out  [CTRL_W] head control, 0 when out_valid==0
//   out_rd     out  [RD_W]   head destination register
//   clr_cnt    in   synchronous clear of both counters (wins over increment)
//   stall_cnt  out  [CNT_W]  cycles with out_valid && !out_ready
//   bubble_cnt out  [CNT_W]  cycles with out_valid==0

module pipe_stage_reg #(
    parameter int DATA_W = 192,
    parameter int CTRL_W = 16,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [RD_W-1:0]   r_main_rd;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [RD_W-1:0]   r_skid_rd;

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_acc;
    logic              w_pop;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid_in;

    // Increment that holds at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    assign w_in_ready  = (r_state != FULL);
    assign w_out_valid = (r_state != EMPTY);
    assign w_acc       = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and entry load decode
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        if (flush) begin
            // Input of this cycle is dropped; a pop still counts as consumed.
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt    = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_pop && w_acc) begin
                        w_load_main_in = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = EMPTY;
                    end else if (w_acc) begin
                        w_state_nxt    = FULL;
                        w_load_skid_in = 1'b1;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_state_nxt      = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Entry storage; flush only zeroes ctrl so squashed entries become no-ops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_main_rd   <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_rd   <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
                r_main_rd   <= in_rd;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
                r_main_rd   <= r_skid_rd;
            end
            if (w_load_skid_in) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
                r_skid_rd   <= in_rd;
            end
        end
    end

    // Performance counters, qualified on the pre-update (pre-flush) state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_out_valid && !out_ready) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (!w_out_valid) begin
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = r_main_data;
    assign out_ctrl   = w_out_valid ? r_main_ctrl : '0;
    assign out_rd     = r_main_rd;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg (CNT_W=4 so saturation is reachable).
module tb_pipe_stage_reg;

    localparam int DATA_W = 192;
    localparam int CTRL_W = 16;
    localparam int RD_W   = 5;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [RD_W-1:0]   in_rd;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [RD_W-1:0]   out_rd;
    logic              clr_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_checks;
    int n_errors;

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .RD_W  (RD_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .clr_cnt   (clr_cnt),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] pay(input logic [RD_W-1:0] rd);
        return {6{32'hA5000000 | 32'(rd)}};
    endfunction

    task automatic drive(input logic v, input logic [RD_W-1:0] rd);
        in_valid = v;
        in_rd    = rd;
        in_data  = pay(rd);
        in_ctrl  = 16'h0100 | 16'(rd);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = '0;
        in_ctrl   = 16'hFFFF;
        in_rd     = 5'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;

        // Reset holds everything cleared even with a valid input present
        tick();
        tick();
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_ctrl",  256'(out_ctrl),  256'(0));
        check("rst_in_ready",  256'(in_ready),  256'(1));
        check("rst_out_data",  256'(out_data),  256'(0));
        check("rst_out_rd",    256'(out_rd),    256'(0));
        check("rst_stall",     256'(stall_cnt), 256'(0));
        check("rst_bubble",    256'(bubble_cnt),256'(0));
        reset = 1'b1;
        tick();
        check("rel_out_valid", 256'(out_valid), 256'(1));
        check("rel_out_ctrl",  256'(out_ctrl),  256'(16'hFFFF));

        // Drain and clear counters
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("drain_empty", 256'(out_valid), 256'(0));

        // Streaming at full throughput
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 5'(i));
            tick();
            check("str_out_valid", 256'(out_valid), 256'(1));
            check("str_out_rd",    256'(out_rd),    256'(i));
            check("str_in_ready",  256'(in_ready),  256'(1));
        end
        check("str_out_data", 256'(out_data), 256'(pay(5'd8)));
        check("str_stall",    256'(stall_cnt), 256'(0));
        in_valid = 1'b0;
        tick();
        check("str_done_empty", 256'(out_valid), 256'(0));

        // Stall fills the skid; extra input while FULL must be dropped
        out_ready = 1'b0;
        clr_cnt   = 1'b1;
        drive(1'b1, 5'd3);
        tick();
        clr_cnt = 1'b0;
        drive(1'b1, 5'd4);
        tick();
        check("stl_in_ready_full", 256'(in_ready), 256'(0));
        drive(1'b1, 5'd5);
        tick();
        tick();
        tick();
        check("stl_in_ready",  256'(in_ready),  256'(0));
        check("stl_out_rd",    256'(out_rd),    256'(3));
        check("stl_out_ctrl",  256'(out_ctrl),  256'(16'h0103));
        check("stl_stall_cnt", 256'(stall_cnt), 256'(4));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stl_pop_rd",    256'(out_rd),    256'(4));
        check("stl_pop_data",  256'(out_data),  256'(pay(5'd4)));
        check("stl_pop_valid", 256'(out_valid), 256'(1));
        check("stl_pop_ready", 256'(in_ready),  256'(1));
        tick();
        check("stl_drained",   256'(out_valid), 256'(0));

        // Flush from FULL with a valid input presented in the flush cycle
        out_ready = 1'b0;
        clr_cnt   = 1'b1;
        drive(1'b1, 5'd6);
        tick();
        clr_cnt = 1'b0;
        drive(1'b1, 5'd7);
        tick();
        check("fl_pre_full", 256'(in_ready), 256'(0));
        drive(1'b1, 5'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_out_valid", 256'(out_valid), 256'(0));
        check("fl_out_ctrl",  256'(out_ctrl),  256'(0));
        check("fl_in_ready",  256'(in_ready),  256'(1));
        check("fl_stall_pre", 256'(stall_cnt), 256'(2));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_rd9", 256'(out_valid), 256'(0));
        end

        // Back-to-back flush with input offered stays EMPTY
        drive(1'b1, 5'd10);
        flush = 1'b1;
        tick();
        tick();
        check("fl2_empty", 256'(out_valid), 256'(0));
        flush    = 1'b0;
        in_valid = 1'b0;

        // Bubble counter saturation and clear priority
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("sat_cleared", 256'(bubble_cnt), 256'(0));
        for (int i = 0; i < 20; i++) tick();
        check("sat_bubble", 256'(bubble_cnt), 256'(15));
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("sat_clr_wins", 256'(bubble_cnt), 256'(0));
        tick();
        check("sat_reinc", 256'(bubble_cnt), 256'(1));

        // Asynchronous reset while FULL and stalled
        out_ready = 1'b0;
        drive(1'b1, 5'd11);
        tick();
        drive(1'b1, 5'd12);
        tick();
        in_valid = 1'b0;
        tick();
        check("ar_pre_full",  256'(in_ready),  256'(0));
        check("ar_pre_stall", 256'(stall_cnt), 256'(2));
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", 256'(out_valid), 256'(0));
        check("ar_in_ready",  256'(in_ready),  256'(1));
        check("ar_out_ctrl",  256'(out_ctrl),  256'(0));
        check("ar_out_data",  256'(out_data),  256'(0));
        check("ar_out_rd",    256'(out_rd),    256'(0));
        check("ar_stall",     256'(stall_cnt), 256'(0));
        check("ar_bubble",    256'(bubble_cnt),256'(0));
        #1;
        reset = 1'b1;
        drive(1'b1, 5'd13);
        tick();
        check("ar_first_acc", 256'(out_rd),    256'(13));
        check("ar_first_vld", 256'(out_valid), 256'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
